// File: rtl/i2c_master.sv
// Single-master I2C byte transmitter: START, byte writes with ACK sampling, STOP.
// Each bus phase is split into four quarter-bit slots of QTR system clocks.
module i2c_master #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int I2C_FREQ = 100_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       i2c_en,
   input  logic [7:0] tx_data,
   input  logic       sda_in,
   output logic       ready,
   output logic       tx_done,
   output logic       ack_err,
   output logic       scl,
   output logic       sda_o,
   output logic       sda_oe
);

   // QTR must be at least 2 so the quarter counter has a real range.
   localparam int QTR = CLK_FREQ / (4 * I2C_FREQ);
   localparam int CW  = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(QTR - 1);

   typedef enum logic [2:0] {IDLE, START, HOLD, DATA, ACK, STOP} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    q_q, q_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          pend_q, pend_d;
   logic          smp_q, smp_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          scl_q, scl_d;
   logic          sdo_q, sdo_d;
   logic          oe_q, oe_d;
   logic          adv;

   assign adv     = (cnt_q == CNT_MAX);
   assign ready   = ready_q;
   assign tx_done = done_q;
   assign ack_err = err_q;
   assign scl     = scl_q;
   assign sda_o   = sdo_q;
   assign sda_oe  = oe_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = adv ? '0 : cnt_q + 1'b1;
      q_d     = adv ? q_q + 2'd1 : q_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pend_d  = pend_q;
      smp_d   = smp_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      err_d   = err_q;
      scl_d   = scl_q;
      sdo_d   = sdo_q;
      oe_d    = oe_q;
      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            q_d     = '0;
            scl_d   = 1'b1;
            oe_d    = 1'b0;
            sdo_d   = 1'b1;
            ready_d = 1'b1;
            if (start) begin
               state_d = START;
               err_d   = 1'b0;
               oe_d    = 1'b1;
               sdo_d   = 1'b0;
               ready_d = 1'b0;
            end
         end
         START: begin
            if (adv) begin
               if (q_q == 2'd1) scl_d = 1'b0;
               if (q_q == 2'd3) begin
                  state_d = HOLD;
                  ready_d = 1'b1;
               end
            end
         end
         HOLD: begin
            cnt_d = '0;
            q_d   = '0;
            if (i2c_en) begin
               ready_d = 1'b0;
               if (stop) begin
                  state_d = STOP;
                  scl_d   = 1'b0;
                  oe_d    = 1'b1;
                  sdo_d   = 1'b0;
               end else begin
                  state_d = DATA;
                  pend_d  = 1'b1;
               end
            end
         end
         DATA: begin
            // First DATA cycle only captures the byte; quarter timing starts after it.
            if (pend_q) begin
               cnt_d  = '0;
               q_d    = '0;
               pend_d = 1'b0;
               sh_d   = tx_data;
               sdo_d  = tx_data[7];
               oe_d   = 1'b1;
               bit_d  = 3'd7;
            end else if (adv) begin
               if (q_q == 2'd0) scl_d = 1'b1;
               if (q_q == 2'd2) scl_d = 1'b0;
               if (q_q == 2'd3) begin
                  if (bit_q == 3'd0) begin
                     state_d = ACK;
                     oe_d    = 1'b0;
                     sdo_d   = 1'b1;
                  end else begin
                     bit_d = bit_q - 3'd1;
                     sh_d  = {sh_q[6:0], 1'b0};
                     sdo_d = sh_q[6];
                  end
               end
            end
         end
         ACK: begin
            if (adv) begin
               if (q_q == 2'd0) scl_d = 1'b1;
               if (q_q == 2'd2) begin
                  scl_d = 1'b0;
                  smp_d = sda_in;
               end
               if (q_q == 2'd3) begin
                  state_d = HOLD;
                  err_d   = smp_q;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
               end
            end
         end
         STOP: begin
            if (adv) begin
               if (q_q == 2'd0) scl_d = 1'b1;
               if (q_q == 2'd2) begin
                  oe_d  = 1'b0;
                  sdo_d = 1'b1;
               end
               if (q_q == 2'd3) begin
                  state_d = IDLE;
                  ready_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         pend_q  <= 1'b0;
         smp_q   <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         scl_q   <= 1'b1;
         sdo_q   <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         pend_q  <= pend_d;
         smp_q   <= smp_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
         scl_q   <= scl_d;
         sdo_q   <= sdo_d;
         oe_q    <= oe_d;
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master at QTR=10: START/byte/STOP timing, bus bit
// capture, NACK reporting, ignored commands and mid-transfer reset.
module tb_i2c_master;

   logic       clk = 1'b0;
   logic       reset, start, stop, i2c_en, sda_in;
   logic [7:0] tx_data;
   logic       ready, tx_done, ack_err, scl, sda_o, sda_oe;

   int n_tests = 0;
   int n_fail  = 0;

   // bus monitor state, written only by the monitor process
   int   cyc = 0;
   int   start_ev = 0;
   int   stop_ev = 0;
   int   done_cnt = 0;
   logic bits[$];
   logic prev_scl = 1'b1;
   logic prev_line = 1'b1;

   always #5 clk = ~clk;

   i2c_master #(.CLK_FREQ(4_000_000), .I2C_FREQ(100_000)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .i2c_en(i2c_en),
      .tx_data(tx_data), .sda_in(sda_in), .ready(ready), .tx_done(tx_done),
      .ack_err(ack_err), .scl(scl), .sda_o(sda_o), .sda_oe(sda_oe)
   );

   // open-drain line with pull-up; data bits captured on SCL rise
   always @(negedge clk) begin
      logic line;
      line = sda_oe ? sda_o : 1'b1;
      cyc++;
      if (scl === 1'b1 && prev_scl === 1'b0 && sda_oe === 1'b1) bits.push_back(line);
      if (scl === 1'b1 && prev_scl === 1'b1 && line !== prev_line) begin
         if (line === 1'b0) start_ev++;
         else stop_ev++;
      end
      if (tx_done === 1'b1) done_cnt++;
      prev_scl  = scl;
      prev_line = line;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input string tag);
      int sb, c0;
      sb = start_ev;
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_ready0"}, ready, 0);
      check({tag, "_scl_hi"}, scl, 1);
      check({tag, "_sda_drv"}, {sda_oe, sda_o}, 2'b10);
      check({tag, "_ackerr_clr"}, ack_err, 0);
      c0 = cyc;
      while (ready !== 1'b1 && cyc - c0 < 200) tick();
      check({tag, "_len"}, cyc - c0, 40);
      check({tag, "_event"}, start_ev - sb, 1);
      check({tag, "_hold_scl"}, scl, 0);
   endtask

   task automatic send_byte(input string tag, input logic [7:0] d, input logic nack,
                            input bit tamper);
      int base, dbase, c0;
      logic [7:0] got;
      base  = bits.size();
      dbase = done_cnt;
      tx_data = d;
      sda_in  = nack;
      stop    = 1'b0;
      i2c_en  = 1'b1;
      tick();
      i2c_en = 1'b0;
      c0 = cyc;
      check({tag, "_accept_ready0"}, ready, 0);
      tick();
      if (tamper) begin
         tx_data = ~d;
         repeat (50) tick();
         i2c_en = 1'b1;
         start  = 1'b1;
         tick();
         i2c_en = 1'b0;
         start  = 1'b0;
         repeat (20) tick();
         stop   = 1'b1;
         i2c_en = 1'b1;
         tick();
         stop   = 1'b0;
         i2c_en = 1'b0;
         check({tag, "_busy_ready0"}, ready, 0);
      end
      while (tx_done !== 1'b1 && cyc - c0 < 1000) tick();
      check({tag, "_latency"}, cyc - c0, 361);
      check({tag, "_ready1"}, ready, 1);
      check({tag, "_ackerr"}, ack_err, nack);
      tick();
      check({tag, "_done_pulse"}, tx_done, 0);
      check({tag, "_done_cnt"}, done_cnt - dbase, 1);
      check({tag, "_nbits"}, bits.size() - base, 8);
      got = '0;
      for (int i = 0; i < 8; i++)
         if (base + i < bits.size()) got = {got[6:0], bits[base + i]};
      check({tag, "_bits"}, got, d);
   endtask

   task automatic do_stop(input string tag);
      int sb, c0;
      sb = stop_ev;
      stop   = 1'b1;
      i2c_en = 1'b1;
      tick();
      stop   = 1'b0;
      i2c_en = 1'b0;
      check({tag, "_ready0"}, ready, 0);
      c0 = cyc;
      while (ready !== 1'b1 && cyc - c0 < 200) tick();
      check({tag, "_len"}, cyc - c0, 40);
      tick();
      check({tag, "_event"}, stop_ev - sb, 1);
      check({tag, "_idle_bus"}, {scl, sda_oe}, 2'b10);
   endtask

   initial begin
      int d0, base, c0;
      reset = 1'b1; start = 1'b0; stop = 1'b0; i2c_en = 1'b0;
      sda_in = 1'b0; tx_data = 8'h00;
      repeat (3) tick();
      check("rst_scl", scl, 1);
      check("rst_sda", {sda_oe, sda_o}, 2'b01);
      check("rst_ready", ready, 1);
      check("rst_flags", {tx_done, ack_err}, 2'b00);
      reset = 1'b0;
      tick();

      // command without START is ignored in IDLE
      i2c_en = 1'b1;
      tick();
      i2c_en = 1'b0;
      repeat (3) tick();
      check("idle_ign_ready", ready, 1);
      check("idle_ign_bus", {scl, sda_oe}, 2'b10);

      do_start("start1");

      // START is not repeated from HOLD
      d0 = start_ev;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("hold_ign_ready", ready, 1);
      check("hold_ign_scl", scl, 0);
      check("hold_ign_event", start_ev - d0, 0);

      d0 = done_cnt;
      send_byte("b_aa", 8'hAA, 1'b0, 1'b0);
      send_byte("b_40", 8'h40, 1'b0, 1'b0);
      send_byte("b_12", 8'h12, 1'b0, 1'b0);
      send_byte("b_34", 8'h34, 1'b1, 1'b1);
      check("xfer_done_total", done_cnt - d0, 4);
      do_stop("stop1");
      check("idle_ready", ready, 1);
      check("ackerr_kept", ack_err, 1);

      do_start("start2");
      send_byte("b_c3", 8'hC3, 1'b0, 1'b0);

      // reset while bit 3 is on the bus
      base = bits.size();
      tx_data = 8'h5A;
      i2c_en  = 1'b1;
      tick();
      i2c_en = 1'b0;
      c0 = cyc;
      while (bits.size() - base < 5 && cyc - c0 < 1000) tick();
      check("mid_bits_seen", bits.size() - base, 5);
      reset = 1'b1;
      #1;
      check("mid_rst_scl", scl, 1);
      check("mid_rst_oe", sda_oe, 0);
      check("mid_rst_ready", ready, 1);
      tick();
      reset = 1'b0;
      tick();
      do_start("start3");
      send_byte("b_81", 8'h81, 1'b0, 1'b0);
      do_stop("stop2");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter I2C_FREQ, default 100_000, SCL frequency in Hz; QTR = CLK_FREQ/(4*I2C_FREQ) clock cycles per quarter-bit; QTR SHALL be at least 2.
REQ-003 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to generate a START condition.
REQ-006 stop  input  1  qualifies i2c_en: when high, the command is a STOP condition rather than a byte.
REQ-007 i2c_en  input  1  one-cycle command strobe (byte send, or STOP when stop=1).
REQ-008 tx_data  input  8  byte to transmit, MSB first.
REQ-009 sda_in  input  1  sampled SDA line level.
REQ-010 ready  output  1  high when a new command is accepted.
REQ-011 tx_done  output  1  one-cycle pulse at the end of each byte's ACK bit.
REQ-012 ack_err  output  1  high when the last ACK bit sampled SDA=1 (NACK).
REQ-013 scl  output  1  SCL level.
REQ-014 sda_o  output  1  SDA drive value; sda_oe  output  1  SDA drive enable (0 = released).

Function
REQ-015 States SHALL be IDLE, START, HOLD, DATA, ACK and STOP; a quarter counter (0..QTR-1) and a quarter index q (0..3) SHALL sequence each phase.
REQ-016 IDLE: scl=1, sda released, ready=1; start=1 -> START; i2c_en without a prior START SHALL be ignored.
REQ-017 START: ready=0; q0-q1 scl=1, sda driven 0; q2-q3 scl=0, sda driven 0; at the end of q3 -> HOLD.
REQ-018 HOLD: scl=0, SDA holds its last driven value, ready=1; i2c_en=1 with stop=0 -> DATA; i2c_en=1 with stop=1 -> STOP; start SHALL be ignored (no repeated START).
REQ-019 Command acceptance: ready SHALL fall on the same edge that samples i2c_en, so ready=0 in the next cycle.
REQ-020 tx_data SHALL be latched on the clock edge one cycle after the edge that accepts i2c_en; later tx_data changes SHALL not affect the byte.
REQ-021 DATA: 8 bits MSB first; per bit: q0 scl=0 with sda_o set to the bit, q1-q2 scl=1, q3 scl=0; sda_oe=1 throughout; after bit 0 -> ACK.
REQ-022 ACK: sda released; same SCL pattern as a data bit; sda_in SHALL be sampled in the last cycle of q2; ack_err SHALL load the sampled value at the end of q3.
REQ-023 At the end of ACK q3: tx_done=1 for exactly one cycle, state -> HOLD, ready=1 from that same registered edge.
REQ-024 STOP: ready=0; q0 scl=0 with sda driven 0; q1-q2 scl=1 with sda driven 0; q3 scl=1 with sda released; at the end of q3 -> IDLE.
REQ-025 ack_err SHALL clear when start is accepted in IDLE; a NACK SHALL not abort the transfer, and the upstream controller still issues STOP.
REQ-026 start, i2c_en and stop arriving in DATA, ACK, START or STOP SHALL be ignored.
REQ-027 All outputs SHALL be registered (no combinational path from inputs to outputs).
REQ-028 Byte duration from acceptance to tx_done SHALL be 1 + 36*QTR cycles (+/-1 for the latch cycle).

Reset
REQ-029 During reset: state=IDLE, counters=0, scl=1, sda_oe=0, sda_o=1, ready=1, tx_done=0, ack_err=0; assertion mid-transfer SHALL release the bus immediately, without a STOP.

Verification
REQ-030 Parameters CLK_FREQ=4_000_000 and I2C_FREQ=100_000 (QTR=10); start pulse -> SDA falls while scl=1, ready returns to 1 after 40 cycles.
REQ-031 i2c_en with tx_data=8'hAA, sda_in=0 on ACK -> SDA bits 1,0,1,0,1,0,1,0 are stable across each SCL high; tx_done pulses once, about 361 cycles after i2c_en; ack_err=0.
REQ-032 Full transaction START, 8'hAA, 8'h40, 8'h12, 8'h34, STOP (stop=1, i2c_en=1) -> 4 tx_done pulses; SDA rises while scl=1; IDLE with ready=1.
REQ-033 sda_in=1 during ACK -> ack_err=1 after the byte; cleared by the next start.
REQ-034 tx_data changed two cycles after i2c_en, and i2c_en re-pulsed mid-byte -> original byte transmitted, extra command ignored.
REQ-035 reset asserted mid-DATA bit 3 -> scl=1, sda_oe=0, ready=1 immediately; the next start begins a clean START.
